// File: rtl/ela_pkg.sv
// Shared constants and arbiter state encoding for the ELA buffer arbiter.
package ela_pkg;

   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned MAX_BURST = 32;
   localparam int unsigned BEAT_W    = 6;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StGnt0 = 2'd1,
      StGnt1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/ela_mem_arb.sv
// Two-master round-robin arbiter in front of a single-port 1024x8 buffer.
// m0 is the loader, m1 the interpolation engine. One beat per cycle, with
// registered memory drive and a two-stage tagged read return.
module ela_mem_arb
   import ela_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   // Loader
   input  logic              m0_req,
   input  logic              m0_wen,
   input  logic              m0_last,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   // Interpolation engine
   input  logic              m1_req,
   input  logic              m1_wen,
   input  logic              m1_last,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   // Buffer
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   // Beat index at which a burst without last becomes preemptible.
   localparam logic [BEAT_W-1:0] BeatLimit = BEAT_W'(MAX_BURST - 1);
   localparam logic [BEAT_W-1:0] BeatSat   = BEAT_W'(MAX_BURST);

   arb_state_e state_q, state_d;

   logic              rr_ptr_q, rr_ptr_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic              mem_wen_q, mem_wen_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   // Read tags: stage 1 marks the cycle the buffer is addressed.
   logic              rd0_q, rd0_d;
   logic              rd1_q, rd1_d;
   logic              m0_rvalid_q, m0_rvalid_d;
   logic              m1_rvalid_q, m1_rvalid_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

   logic acc0, acc1;
   logic limit_hit;
   logic rel0, rel1;
   logic new_grant;

   assign acc0      = m0_req & (state_q == StGnt0);
   assign acc1      = m1_req & (state_q == StGnt1);
   assign limit_hit = (beat_cnt_q >= BeatLimit);

   // While granted, a high req is an accepted beat, so last/limit act on it directly.
   assign rel0 = ~m0_req | m0_last | (limit_hit & m1_req);
   assign rel1 = ~m1_req | m1_last | (limit_hit & m0_req);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: round-robin from idle, direct handover on release
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (m0_req && m1_req) begin
               state_d = rr_ptr_q ? StGnt1 : StGnt0;
            end else if (m0_req) begin
               state_d = StGnt0;
            end else if (m1_req) begin
               state_d = StGnt1;
            end
         end
         StGnt0: begin
            if (rel0) begin
               state_d = m1_req ? StGnt1 : StIdle;
            end
         end
         StGnt1: begin
            if (rel1) begin
               state_d = m0_req ? StGnt0 : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      m0_gnt = (state_q == StGnt0);
      m1_gnt = (state_q == StGnt1);
      busy   = (state_q != StIdle);
   end

   // Next-state for round-robin pointer, beat counter, memory drive and read return
   always_comb begin
      new_grant = (state_d != StIdle) && (state_d != state_q);

      rr_ptr_d = rr_ptr_q;
      if (new_grant) begin
         rr_ptr_d = (state_d == StGnt0);
      end

      beat_cnt_d = beat_cnt_q;
      if (new_grant) begin
         beat_cnt_d = '0;
      end else if ((acc0 || acc1) && (beat_cnt_q < BeatSat)) begin
         beat_cnt_d = beat_cnt_q + 1'b1;
      end

      mem_wen_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (acc0) begin
         mem_wen_d   = m0_wen;
         mem_addr_d  = m0_addr;
         mem_wdata_d = m0_wdata;
      end else if (acc1) begin
         mem_wen_d   = m1_wen;
         mem_addr_d  = m1_addr;
         mem_wdata_d = m1_wdata;
      end

      rd0_d = acc0 & ~m0_wen;
      rd1_d = acc1 & ~m1_wen;

      // Buffer read is asynchronous on mem_addr, valid while the tag is in stage 1.
      m0_rvalid_d = rd0_q;
      m1_rvalid_d = rd1_q;
      m0_rdata_d  = rd0_q ? mem_rdata : m0_rdata_q;
      m1_rdata_d  = rd1_q ? mem_rdata : m1_rdata_q;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= 1'b0;
         beat_cnt_q  <= '0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd0_q       <= 1'b0;
         rd1_q       <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd0_q       <= rd0_d;
         rd1_q       <= rd1_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;

endmodule

// File: doc/ela_mem_arb.md
ELA_MEM_ARB -- requirements
Module: ela_mem_arb

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have m0_req  in  1  loader requests buffer access.
REQ-003 SHALL have m0_wen, m0_last  in  1 each  write enable (1=write, 0=read); last beat of burst.
REQ-004 SHALL have m0_addr  in  10  word address; m0_wdata  in  8  write data.
REQ-005 SHALL have m0_gnt  out  1; m0_rvalid  out  1; m0_rdata  out  8.
REQ-006 SHALL have the same m1_* set (interpolation engine) with identical widths and meaning.
REQ-007 SHALL have mem_wen  out  1, mem_addr  out  10, mem_wdata  out  8, mem_rdata  in  8 (single-port 1024x8 buffer, asynchronous read of mem_addr).
REQ-008 SHALL have busy  out  1  high while any grant is held.

Function
REQ-009 SHALL implement FSM states IDLE, GNT0, GNT1; mX_gnt = (state==GNTX), registered.
REQ-010 SHALL define beat accepted: mX_req & mX_gnt in a cycle.
REQ-011 In IDLE, single requester SHALL be granted next cycle; both requesting SHALL grant the master selected by rr_ptr (reset value 0 = m0).
REQ-012 On each grant, rr_ptr SHALL point to the other master.
REQ-013 Grant SHALL release on: accepted beat with mX_last=1; mX_req low while granted; or forced preemption (REQ-015).
REQ-014 On release, if the other master requests, SHALL move directly to its grant state (no idle bubble); else SHALL go to IDLE (re-request costs one bubble cycle).
REQ-015 SHALL count accepted beats per grant (6-bit beat_cnt, cleared on grant); on the 32nd accepted beat without last, grant SHALL be withdrawn only if the other master requests; otherwise beat_cnt saturates and the grant continues.
REQ-016 Preempted master SHALL hold req/addr; its unaccepted beat is re-presented at its next grant.
REQ-017 Accepted beat in cycle N SHALL drive mem_addr/mem_wdata/mem_wen registered, visible in cycle N+1.
REQ-018 mem_wen SHALL be 1 only in cycles following an accepted write; 0 otherwise. mem_addr and mem_wdata SHALL hold last value when no access.
REQ-019 Accepted read in cycle N SHALL return mem_rdata registered to mX_rdata with mX_rvalid=1 in cycle N+2, routed to the issuing master even if grant has since moved.
REQ-020 mX_rvalid SHALL be a one-cycle pulse per read; never asserted for writes; mX_rdata holds between pulses.
REQ-021 Back-to-back accepted beats SHALL sustain one access per cycle.
REQ-022 Requests with gnt low SHALL have no effect on memory outputs.

Reset
REQ-023 On rst: state=IDLE, rr_ptr=0, beat_cnt=0, m0_gnt=m1_gnt=0, busy=0, mem_wen=0, mem_addr=0, mem_wdata=0, m0/m1_rvalid=0, m0/m1_rdata=0.
REQ-024 rst mid-burst SHALL abort: in-flight read pipeline dropped, no rvalid after reset; mem_wen low from the first cycle after the reset edge.

Structure
REQ-025 Shared package ela_pkg SHALL hold ADDR_W=10, DATA_W=8, MAX_BURST=32 and the arbiter state enumeration.
REQ-026 SHALL be a single module, no sub-modules; the 2-stage read-return tag pipeline lives inline.

Verification
REQ-027 m0 alone writes 32 beats addr 0..31 data 0x10..0x2F, last on beat 32 -> mem_wen high cycles N+1..N+32 with matching addr/data; m0_gnt drops next cycle; state IDLE.
REQ-028 m0 and m1 request same cycle after reset -> m0 granted first; after m0 last, m1_gnt=1 next cycle with m0_gnt=0 (no bubble).
REQ-029 m1 reads addr 0x040, mem holds 0xA5 -> m1_rvalid=1, m1_rdata=0xA5 exactly two cycles after acceptance; m0_rvalid stays 0.
REQ-030 m0 burst of 40 beats without last while m1 requests -> m0_gnt drops after 32nd accepted beat, m1 granted; m0 resumes beat 33 (addr 32) on regrant.
REQ-031 m0 reads, grant passes to m1 in the next cycle -> read data still returned on m0_rvalid/m0_rdata.
REQ-032 rst asserted during m1 read burst -> all gnt/rvalid/mem_wen 0 next cycle; after release, simultaneous requests grant m0.
